ram_port_arbiter: RTL and testbench

Arbiter and initialiser for the 256 x 8 single-port RAM: it shares the RAM's one address/data/write port between two requesters, A and B, using round-robin arbitration. One operation is issued per cycle, and read data is returned with a fixed latency. After every reset it can optionally sweep the whole array to a known value before accepting requests. It sits directly in front of the RAM; the requesters never drive the RAM themselves.

---
 rtl/ram_port_arbiter_if.sv | 35 +++
 rtl/ram_port_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester, RAM-side and status signals of the two-port RAM arbiter.
// slave: the arbiter; master: whatever drives the requests and models the RAM.
interface ram_port_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic       we_a;
    logic       we_b;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [7:0] wdata_a;
    logic [7:0] wdata_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       rvalid_a;
    logic       rvalid_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_wr;
    logic [7:0] ram_dout;
    logic       init_done;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_dout,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
               ram_addr, ram_din, ram_wr, init_done
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_dout,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
               ram_addr, ram_din, ram_wr, init_done
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of a 256x8 single-port RAM between requesters A and B,
// with an optional fill sweep after reset and a fixed two-cycle read return.
module ram_port_arbiter #(
    parameter bit         INIT_ON_RESET = 1'b1,
    parameter logic [7:0] INIT_VALUE    = 8'h00
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_last_b;
    logic       w_last_b_nxt;
    logic       r_init_done;
    logic       w_init_done_nxt;
    logic [7:0] r_ram_addr;
    logic [7:0] w_ram_addr_nxt;
    logic [7:0] r_ram_din;
    logic [7:0] w_ram_din_nxt;
    logic       r_ram_wr;
    logic       w_ram_wr_nxt;
    logic       r_rd_vld_p0;
    logic       w_rd_vld_nxt;
    logic       r_rd_own_b_p0;
    logic       w_rd_own_b_nxt;
    logic       r_rvalid_a_p1;
    logic       r_rvalid_b_p1;
    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_pick_a;

    always_ff @(posedge clk) begin
        if (rst) r_state <= INIT_ON_RESET ? ST_INIT : ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Grants are gated by the registered init_done so that, with no sweep,
    // the first grant still lands one edge after reset is released.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        w_last_b_nxt    = r_last_b;
        w_gnt_a         = 1'b0;
        w_gnt_b         = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_din_nxt   = r_ram_din;
        w_ram_wr_nxt    = 1'b0;
        w_rd_vld_nxt    = 1'b0;
        w_rd_own_b_nxt  = 1'b0;
        w_pick_a        = bus.req_a && (!bus.req_b || r_last_b);

        case (r_state)
            ST_INIT: begin
                w_ram_addr_nxt = r_cnt;
                w_ram_din_nxt  = INIT_VALUE;
                w_ram_wr_nxt   = 1'b1;
                w_cnt_nxt      = r_cnt + 8'd1;
                if (r_cnt == 8'hFF) begin
                    w_state_nxt     = ST_RUN;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                w_init_done_nxt = 1'b1;
                if (r_init_done && !rst) begin
                    w_gnt_a = w_pick_a;
                    w_gnt_b = bus.req_b && !w_pick_a;
                end
                if (w_gnt_a) begin
                    w_ram_addr_nxt = bus.addr_a;
                    w_ram_din_nxt  = bus.wdata_a;
                    w_ram_wr_nxt   = bus.we_a;
                    w_rd_vld_nxt   = !bus.we_a;
                    w_rd_own_b_nxt = 1'b0;
                    w_last_b_nxt   = 1'b0;
                end else if (w_gnt_b) begin
                    w_ram_addr_nxt = bus.addr_b;
                    w_ram_din_nxt  = bus.wdata_b;
                    w_ram_wr_nxt   = bus.we_b;
                    w_rd_vld_nxt   = !bus.we_b;
                    w_rd_own_b_nxt = 1'b1;
                    w_last_b_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // p0: issue register toward the RAM; p1: read-return flag aligned with ram_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 8'd0;
            r_last_b      <= 1'b1;
            r_init_done   <= 1'b0;
            r_ram_addr    <= 8'd0;
            r_ram_din     <= 8'd0;
            r_ram_wr      <= 1'b0;
            r_rd_vld_p0   <= 1'b0;
            r_rd_own_b_p0 <= 1'b0;
            r_rvalid_a_p1 <= 1'b0;
            r_rvalid_b_p1 <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_last_b      <= w_last_b_nxt;
            r_init_done   <= w_init_done_nxt;
            r_ram_addr    <= w_ram_addr_nxt;
            r_ram_din     <= w_ram_din_nxt;
            r_ram_wr      <= w_ram_wr_nxt;
            r_rd_vld_p0   <= w_rd_vld_nxt;
            r_rd_own_b_p0 <= w_rd_own_b_nxt;
            r_rvalid_a_p1 <= r_rd_vld_p0 && !r_rd_own_b_p0;
            r_rvalid_b_p1 <= r_rd_vld_p0 && r_rd_own_b_p0;
        end
    end

    assign bus.gnt_a     = w_gnt_a;
    assign bus.gnt_b     = w_gnt_b;
    assign bus.rvalid_a  = r_rvalid_a_p1;
    assign bus.rvalid_b  = r_rvalid_b_p1;
    assign bus.rdata_a   = bus.ram_dout;
    assign bus.rdata_b   = bus.ram_dout;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.init_done = r_init_done;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed steps plus random traffic, checked
// against a transaction-level model (memory array + queue of pending reads).
module tb_ram_port_arbiter;
    localparam logic [7:0] FILL = 8'hA5;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if bus();
    ram_port_arbiter_if bus2();

    ram_port_arbiter #(.INIT_ON_RESET(1'b1), .INIT_VALUE(FILL)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ram_port_arbiter #(.INIT_ON_RESET(1'b0), .INIT_VALUE(8'h00)) u_dut2 (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    // Physical RAMs: registered read, write on ram_wr
    logic [7:0] ram1 [256];
    logic [7:0] ram2 [256];
    always @(posedge clk) begin
        if (bus.ram_wr === 1'b1) ram1[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram1[bus.ram_addr];
    end
    always @(posedge clk) begin
        if (bus2.ram_wr === 1'b1) ram2[bus2.ram_addr] <= bus2.ram_din;
        bus2.ram_dout <= ram2[bus2.ram_addr];
    end

    // Reference model
    typedef struct {
        int         due;
        bit         own_b;
        logic [7:0] data;
    } rd_t;
    rd_t        m_q[$];
    logic [7:0] m_mem [256];
    bit         m_last_b;
    bit         m_run;
    int         init_cnt;
    int         cyc;
    int         n_vec = 0;
    int         n_err = 0;
    bit         t_ga, t_gb;
    logic       o_ga, o_gb;
    bit         a_pend, b_pend;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic r, input logic w, input logic [7:0] ad, input logic [7:0] d);
        bus.req_a = r; bus.we_a = w; bus.addr_a = ad; bus.wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [7:0] ad, input logic [7:0] d);
        bus.req_b = r; bus.we_b = w; bus.addr_b = ad; bus.wdata_b = d;
    endtask

    // One clock: check outputs at the falling edge, then advance the model
    // by whatever the rising edge does.
    task automatic tick();
        bit         ea, eb, we;
        logic [7:0] ed, ad, wd;
        @(negedge clk);
        t_ga = 1'b0;
        t_gb = 1'b0;
        if (m_run && rst == 1'b0) begin
            if (bus.req_a && (!bus.req_b || m_last_b)) t_ga = 1'b1;
            else if (bus.req_b)                        t_gb = 1'b1;
        end
        o_ga = bus.gnt_a;
        o_gb = bus.gnt_b;
        chk1("gnt_a", bus.gnt_a, t_ga);
        chk1("gnt_b", bus.gnt_b, t_gb);
        ea = 1'b0; eb = 1'b0; ed = 8'h00;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            ea = !m_q[0].own_b;
            eb = m_q[0].own_b;
            ed = m_q[0].data;
            void'(m_q.pop_front());
        end
        chk1("rvalid_a", bus.rvalid_a, ea);
        chk1("rvalid_b", bus.rvalid_b, eb);
        if (ea) chk8("rdata_a", bus.rdata_a, ed);
        if (eb) chk8("rdata_b", bus.rdata_b, ed);
        chk1("init_done", bus.init_done, m_run);
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_q.delete();
            m_last_b = 1'b1;
            m_run    = 1'b0;
            init_cnt = 0;
        end else if (t_ga || t_gb) begin
            if (t_ga) begin we = bus.we_a; ad = bus.addr_a; wd = bus.wdata_a; end
            else      begin we = bus.we_b; ad = bus.addr_b; wd = bus.wdata_b; end
            if (we) m_mem[ad] = wd;
            else    m_q.push_back('{cyc + 1, t_gb, m_mem[ad]});
            m_last_b = t_gb;
        end else if (!m_run) begin
            m_mem[init_cnt[7:0]] = FILL;
            init_cnt++;
            if (init_cnt == 256) m_run = 1'b1;
        end
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        set_a(1'b1, 1'b0, 8'h00, 8'h00);
        set_b(1'b1, 1'b0, 8'hFF, 8'h00);
        bus2.req_a = 1'b0; bus2.we_a = 1'b0; bus2.addr_a = 8'h00; bus2.wdata_a = 8'h00;
        bus2.req_b = 1'b0; bus2.we_b = 1'b0; bus2.addr_b = 8'h00; bus2.wdata_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_gnt_a", bus.gnt_a, 1'b0);
        chk1("rst_gnt_b", bus.gnt_b, 1'b0);
        chk1("rst_rvalid_a", bus.rvalid_a, 1'b0);
        chk1("rst_rvalid_b", bus.rvalid_b, 1'b0);
        chk1("rst_ram_wr", bus.ram_wr, 1'b0);
        chk8("rst_ram_addr", bus.ram_addr, 8'h00);
        chk8("rst_ram_din", bus.ram_din, 8'h00);
        chk1("rst_init_done", bus.init_done, 1'b0);
        m_last_b = 1'b1; m_run = 1'b0; init_cnt = 0; cyc = 0;
        rst = 1'b0;

        // Init sweep with both requesters already waiting
        for (int i = 0; i < 256; i++) begin
            tick();
            chk1("init_wr", bus.ram_wr, 1'b1);
            chk8("init_addr", bus.ram_addr, 8'(i));
            chk8("init_din", bus.ram_din, FILL);
        end

        // Read-back of the fill: 0x00 in the first RUN cycle, then 0xFF, 0x7F
        tick();
        chk1("first_run_gnt_a", o_ga, 1'b1);
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk1("fill_gnt_b", o_gb, 1'b1);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        set_a(1'b1, 1'b0, 8'h7F, 8'h00);
        tick();
        chk1("fill_gnt_a", o_ga, 1'b1);
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        drain(3);

        // Single requester write then read
        set_a(1'b1, 1'b1, 8'h10, 8'h3C);
        tick();
        chk1("single_wr_gnt", o_ga, 1'b1);
        set_a(1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        chk1("single_rd_gnt", o_ga, 1'b1);
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk1("single_rvalid_a", bus.rvalid_a, 1'b1);
        chk8("single_rdata_a", bus.rdata_a, 8'h3C);
        chk1("single_rvalid_b", bus.rvalid_b, 1'b0);
        drain(2);

        // Contention: B writes last, so sustained reads start with A
        set_a(1'b1, 1'b1, 8'h01, 8'h11);
        tick();
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b1, 1'b1, 8'h02, 8'h22);
        tick();
        set_a(1'b1, 1'b0, 8'h01, 8'h00);
        set_b(1'b1, 1'b0, 8'h02, 8'h00);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk1("cont_excl", o_ga & o_gb, 1'b0);
            chk1("cont_seq_a", o_ga, 1'((k % 2) == 0));
            chk1("cont_seq_b", o_gb, 1'((k % 2) == 1));
        end
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        drain(3);

        // Cross-requester read-after-write
        set_a(1'b1, 1'b1, 8'h20, 8'h77);
        tick();
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk1("raw_rvalid_b", bus.rvalid_b, 1'b1);
        chk8("raw_rdata_b", bus.rdata_b, 8'h77);
        chk1("raw_rvalid_a", bus.rvalid_a, 1'b0);
        drain(2);

        // Reset on the edge after a read transfer
        set_a(1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        chk1("mid_rst_ram_wr", bus.ram_wr, 1'b0);
        chk1("mid_rst_rvalid_a", bus.rvalid_a, 1'b0);
        tick();
        chk1("mid_rst_ram_wr2", bus.ram_wr, 1'b0);
        chk8("mid_rst_ram_addr", bus.ram_addr, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk1("reinit_wr", bus.ram_wr, 1'b1);
            chk8("reinit_addr", bus.ram_addr, 8'(i));
        end
        drain(1);

        // Random traffic on a narrow address window to provoke hazards
        a_pend = 1'b0;
        b_pend = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                set_a(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                a_pend = 1'b1;
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                set_b(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                b_pend = 1'b1;
            end
            tick();
            if (o_ga === 1'b1) begin a_pend = 1'b0; set_a(1'b0, 1'b0, 8'h00, 8'h00); end
            if (o_gb === 1'b1) begin b_pend = 1'b0; set_b(1'b0, 1'b0, 8'h00, 8'h00); end
        end
        set_a(1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 8'h00, 8'h00);
        drain(4);

        // No-sweep instance: A granted right after the first edge with rst low
        bus2.req_a = 1'b1; bus2.we_a = 1'b1; bus2.addr_a = 8'h33; bus2.wdata_a = 8'h5A;
        @(negedge clk);
        chk1("d2_rst_gnt_a", bus2.gnt_a, 1'b0);
        chk1("d2_rst_init_done", bus2.init_done, 1'b0);
        chk1("d2_rst_ram_wr", bus2.ram_wr, 1'b0);
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        chk1("d2_pre_init_done", bus2.init_done, 1'b0);
        chk1("d2_pre_gnt_a", bus2.gnt_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("d2_init_done", bus2.init_done, 1'b1);
        chk1("d2_gnt_a", bus2.gnt_a, 1'b1);
        chk1("d2_gnt_b", bus2.gnt_b, 1'b0);
        @(posedge clk);
        #1;
        chk1("d2_wr", bus2.ram_wr, 1'b1);
        chk8("d2_addr", bus2.ram_addr, 8'h33);
        chk8("d2_din", bus2.ram_din, 8'h5A);
        bus2.we_a = 1'b0;
        @(negedge clk);
        chk1("d2_rd_gnt_a", bus2.gnt_a, 1'b1);
        @(posedge clk);
        #1 bus2.req_a = 1'b0;
        chk1("d2_rd_wr", bus2.ram_wr, 1'b0);
        @(posedge clk);
        #1;
        chk1("d2_rvalid_a", bus2.rvalid_a, 1'b1);
        chk8("d2_rdata_a", bus2.rdata_a, 8'h5A);
        chk1("d2_rvalid_b", bus2.rvalid_b, 1'b0);
        @(posedge clk);
        #1;
        chk1("d2_rvalid_a_end", bus2.rvalid_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
